fpu_issue_ctrl: RTL
===================

# fpu_issue_ctrl

Front-end issue stage that sits directly upstream of the `FPU` core. It buffers operation requests in a small FIFO, drives one request at a time onto the FPU operand/opcode inputs, and generates the FPU start pulse on the FPU's `Reset` input. It then waits for the FPU `Done` rising edge, captures `Result`, and presents it on a valid/ready response port.

## Interface
- `PRECISION`, 32: operand/result width; matches `FPU` `PRECISION`.
- `DEPTH`, 4: request FIFO entries; power of two, ≥2.
- `START_CYCLES`, 2: cycles `FpuStart` is held high per operation; ≥1.
- `TIMEOUT`, 64: WAIT-state cycle limit; used only with `FPU_ISSUE_TIMEOUT_EN`.

- `Clk` in 1: clock; all logic on rising edge.
- `Reset` in 1: synchronous, active-high block reset.
- `ReqValid` in 1: request present.
- `ReqReady` out 1: FIFO not full.
- `ReqA`, `ReqB` in PRECISION: operands.
- `ReqOp` in 2: 00 add, 01 sub, 10 mul, 11 div.
- `FpuA`, `FpuB` out PRECISION: to FPU operand inputs; registered.
- `FpuOp` out 2: to FPU `Operation`; registered.
- `FpuStart` out 1: to FPU `Reset`; high = FPU held in reset/start.
- `FpuResult` in PRECISION: from FPU `Result`.
- `FpuDone` in 1: from FPU `Done`.
- `RspValid` out 1, `RspReady` in 1: response handshake.
- `RspData` out PRECISION: captured result.
- `RspOp` out 2: opcode of the completed request.
- `RspTimeout` out 1: response produced by timeout.
- `Busy` out 1: FSM not in IDLE, or FIFO not empty.

## Operation
- Push when `ReqValid && ReqReady`. `ReqReady = !full` is combinational from the FIFO count. There is no bypass: when full, `ReqReady` = 0 even if a pop happens the same cycle.
- FSM states: IDLE, START, WAIT, RESP.
- IDLE: if the FIFO is non-empty, pop the head into `FpuA/FpuB/FpuOp`, then go to START. Otherwise stay.
- START: `FpuStart` = 1 for exactly `START_CYCLES` cycles, counted by a down-counter. After that, `FpuStart` = 0 and the FSM goes to WAIT.
- WAIT: register `FpuDone` into `DoneQ`. On `FpuDone && !DoneQ`, capture `FpuResult` into `RspData` and go to RESP. A level-high `FpuDone` with no rising edge, such as a stale Done from the previous operation, is ignored. `DoneQ` is forced to 1 during START, so a Done that stays high through START never counts.
- RESP: `RspValid` = 1. `RspData`, `RspOp` and `RspTimeout` stay stable until `RspReady`. On handshake, go to IDLE. The next pop can happen on the cycle after the handshake.
- `FpuA/FpuB/FpuOp` hold their values from the pop until the next pop.

## Timing
- Reset values: `ReqReady` 1, `FpuStart` 0, `FpuA/FpuB/RspData` 0, `FpuOp/RspOp` 00, `RspValid` 0, `RspTimeout` 0, `Busy` 0, FSM IDLE, FIFO empty.
- Request accepted at edge N → `FpuStart` high from N+2 through N+1+`START_CYCLES` (FIFO write at N, pop at N+1).
- FPU Done edge sampled at edge M → `RspValid` high from M+1.
- Reset mid-operation: the in-flight operation and all FIFO contents are dropped, with no response. Outputs return to their reset values on the next edge.
- Reset has priority over every handshake in the same cycle.

## Configuration
- `FPU_ISSUE_TIMEOUT_EN` defined: WAIT counts cycles. If `TIMEOUT` cycles pass without a Done edge, go to RESP with `RspData` = quiet NaN (sign 0, exponent all ones, mantissa MSB 1, rest 0; 0x7FC00000 at 32 bits) and `RspTimeout` = 1. A Done edge on the same cycle as the limit wins, giving a normal response.
- Undefined: WAIT waits indefinitely, `RspTimeout` is tied to 0, and `TIMEOUT` is ignored.

## Test plan
- Single add: 1.5 (0x3FC00000) + 1.5, `RspReady`=1 → `FpuStart` high 2 cycles starting 2 cycles after accept; `RspData`=0x40400000, `RspOp`=00, `RspTimeout`=0.
- Back-pressure: with `RspReady`=0, push 6 requests continuously → 4 accepted (plus 1 popped into FPU), then `ReqReady`=0. `RspValid` stays held with a stable first result. Releasing `RspReady` drains all results in order: 0−8=0xC1000000, 0×1=0x00000000, 0/1=0x00000000.
- Stale Done: model holds `FpuDone`=1 through START and the first 3 WAIT cycles, then drops it, then raises it → exactly one capture, on the later rising edge.
- Reset mid-WAIT: assert `Reset` 1 cycle with 2 requests queued → no `RspValid`, `Busy`=0, `ReqReady`=1 next cycle.
- Timeout (macro on, `TIMEOUT`=8, `FpuDone` never rises) → `RspValid` 8 cycles after WAIT entry, `RspData`=0x7FC00000, `RspTimeout`=1. Macro off → FSM remains in WAIT after 1000 cycles.

Source files
------------

// File: rtl/fpu_issue_ctrl.sv
// Issue stage in front of the FPU core: request FIFO, start-pulse sequencer, Done-edge capture and response port.
// Define FPU_ISSUE_TIMEOUT_EN to bound the WAIT state and return a quiet NaN on expiry.
module fpu_issue_ctrl #(
    parameter int PRECISION    = 32,
    parameter int DEPTH        = 4,
    parameter int START_CYCLES = 2,
    parameter int TIMEOUT      = 64
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 ReqValid,
    output logic                 ReqReady,
    input  logic [PRECISION-1:0] ReqA,
    input  logic [PRECISION-1:0] ReqB,
    input  logic [1:0]           ReqOp,
    output logic [PRECISION-1:0] FpuA,
    output logic [PRECISION-1:0] FpuB,
    output logic [1:0]           FpuOp,
    output logic                 FpuStart,
    input  logic [PRECISION-1:0] FpuResult,
    input  logic                 FpuDone,
    output logic                 RspValid,
    input  logic                 RspReady,
    output logic [PRECISION-1:0] RspData,
    output logic [1:0]           RspOp,
    output logic                 RspTimeout,
    output logic                 Busy
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int SC_W  = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

    state_t               state;
    logic [PRECISION-1:0] a_mem  [DEPTH];
    logic [PRECISION-1:0] b_mem  [DEPTH];
    logic [1:0]           op_mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count;
    logic [SC_W-1:0]      start_cnt;
    logic                 done_q;
    logic                 push;
    logic                 pop;
    logic                 done_edge;

`ifdef FPU_ISSUE_TIMEOUT_EN
    localparam int WT_W  = $clog2(TIMEOUT + 1);
    localparam int EXP_W = (PRECISION == 64) ? 11 : (PRECISION == 16) ? 5 : 8;

    logic [WT_W-1:0] wait_cnt;
    logic            rsp_timeout;

    function automatic logic [PRECISION-1:0] quiet_nan();
        logic [PRECISION-1:0] q;
        q = '0;
        q[PRECISION-2 -: EXP_W] = '1;
        q[PRECISION-2-EXP_W]    = 1'b1;
        return q;
    endfunction

    assign RspTimeout = rsp_timeout;
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT);
    assign RspTimeout     = 1'b0;
`endif

    // No bypass: a full FIFO refuses requests even while the FSM pops.
    assign ReqReady  = (count != CNT_W'(DEPTH));
    assign push      = ReqValid && ReqReady;
    assign pop       = (state == IDLE) && (count != '0);
    assign done_edge = FpuDone && !done_q;
    assign Busy      = (state != IDLE) || (count != '0);

    always_ff @(posedge Clk) begin
        if (push) begin
            a_mem[wr_ptr]  <= ReqA;
            b_mem[wr_ptr]  <= ReqB;
            op_mem[wr_ptr] <= ReqOp;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            start_cnt <= '0;
            done_q    <= 1'b1;
            FpuA      <= '0;
            FpuB      <= '0;
            FpuOp     <= '0;
            FpuStart  <= 1'b0;
            RspValid  <= 1'b0;
            RspData   <= '0;
            RspOp     <= '0;
`ifdef FPU_ISSUE_TIMEOUT_EN
            wait_cnt    <= '0;
            rsp_timeout <= 1'b0;
`endif
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(push) - CNT_W'(pop);

            case (state)
                IDLE: begin
                    done_q <= 1'b1;
                    if (pop) begin
                        FpuA      <= a_mem[rd_ptr];
                        FpuB      <= b_mem[rd_ptr];
                        FpuOp     <= op_mem[rd_ptr];
                        FpuStart  <= 1'b1;
                        start_cnt <= SC_W'(START_CYCLES - 1);
                        state     <= START;
                    end
                end
                START: begin
                    // Holding done_q high masks a Done level left over from the previous operation.
                    done_q <= 1'b1;
                    if (start_cnt == '0) begin
                        FpuStart <= 1'b0;
                        state    <= WAIT;
`ifdef FPU_ISSUE_TIMEOUT_EN
                        wait_cnt <= '0;
`endif
                    end else begin
                        start_cnt <= start_cnt - 1'b1;
                    end
                end
                WAIT: begin
                    done_q <= FpuDone;
                    if (done_edge) begin
                        RspData  <= FpuResult;
                        RspOp    <= FpuOp;
                        RspValid <= 1'b1;
                        state    <= RESP;
`ifdef FPU_ISSUE_TIMEOUT_EN
                        rsp_timeout <= 1'b0;
                    end else if (wait_cnt == WT_W'(TIMEOUT - 1)) begin
                        RspData     <= quiet_nan();
                        RspOp       <= FpuOp;
                        RspValid    <= 1'b1;
                        rsp_timeout <= 1'b1;
                        state       <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
`endif
                    end
                end
                RESP: begin
                    if (RspReady) begin
                        RspValid <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
